i2c_reg_bank: RTL

- Register-file stage directly downstream of i2c_peripheral_clk; consumes its received bytes and transaction events, and supplies the byte it transmits.
- Implements a pointer-addressed register map: the first byte of a write transaction loads the pointer, later bytes write registers, reads stream registers out. The pointer auto-increments after every byte.
- Low registers are read/write configuration exported to the rest of the FPGA. High registers are read-only status sourced from sensor logic.

---
 rtl/i2c_reg_bank.sv | 125 ++++++++++++
 1 files changed

// File: rtl/i2c_reg_bank.sv
// Pointer-addressed I2C register bank: low indices are R/W config, high indices are RO status.
// Define REG_BANK_SNAPSHOT_EN to freeze ro_data into a shadow at each read START.
module i2c_reg_bank #(
    parameter int          NUM_REGS = 16,
    parameter int          RO_BASE  = 8,
    parameter logic [7:0]  RW_RESET = 8'h00
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             addr_match,
    input  logic                             rw,
    input  logic                             rx_valid,
    input  logic [7:0]                       rx,
    input  logic                             tx_ready,
    input  logic                             stop_evt,
    input  logic [8*(NUM_REGS-RO_BASE)-1:0]  ro_data,
    output logic [7:0]                       tx,
    output logic [8*RO_BASE-1:0]             rw_regs,
    output logic [RO_BASE-1:0]               wr_strobe,
    output logic [7:0]                       ptr,
    output logic                             err,
    output logic                             debug
);
    localparam int         RO_N       = NUM_REGS - RO_BASE;
    localparam logic [8:0] NUM_REGS_W = 9'(NUM_REGS);
    localparam logic [8:0] RO_BASE_W  = 9'(RO_BASE);
    localparam logic [8:0] LAST_W     = 9'(NUM_REGS - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] PTR   = 2'd1;
    localparam logic [1:0] WDATA = 2'd2;
    localparam logic [1:0] RDATA = 2'd3;

    logic [1:0]             r_state;
    logic [7:0]             r_ptr;
    logic [7:0]             r_tx;
    logic                   r_err;
    logic [8*RO_BASE-1:0]   r_rw_regs;
    logic [RO_BASE-1:0]     r_wr_strobe;

    logic [1:0]             w_state_nxt;
    logic [7:0]             w_ptr_inc;
    logic [7:0]             w_rd_byte;
    logic [8*RO_N-1:0]      w_ro_src;
    logic                   w_load_ptr;
    logic                   w_do_write;
    logic                   w_inc;
    logic                   w_tx_upd;

`ifdef REG_BANK_SNAPSHOT_EN
    logic [8*RO_N-1:0]      r_shadow;

    always_ff @(posedge clk) begin
        if (addr_match && rw) r_shadow <= ro_data;
    end

    // The first tx byte is loaded on the same edge the shadow is captured.
    assign w_ro_src = (addr_match && rw) ? ro_data : r_shadow;
`else
    assign w_ro_src = ro_data;
`endif

    // An address match pre-empts any data byte or tx_ready in the same cycle.
    assign w_load_ptr = (r_state == PTR) && rx_valid && !addr_match;
    assign w_do_write = (r_state == WDATA) && rx_valid && !addr_match && ({1'b0, r_ptr} < RO_BASE_W);
    assign w_inc      = !addr_match && (((r_state == WDATA) && rx_valid) ||
                                        ((r_state == RDATA) && tx_ready));
    assign w_tx_upd   = addr_match ? rw : (r_state == RDATA);
    assign w_ptr_inc  = ({1'b0, r_ptr} == LAST_W) ? 8'h00 : r_ptr + 8'h01;

    always_comb begin
        w_rd_byte = 8'hFF;
        for (int i = 0; i < RO_BASE; i++)
            if (r_ptr == 8'(i)) w_rd_byte = r_rw_regs[i*8 +: 8];
        for (int i = 0; i < RO_N; i++)
            if (r_ptr == 8'(RO_BASE + i)) w_rd_byte = w_ro_src[i*8 +: 8];
    end

    always_comb begin
        w_state_nxt = r_state;
        if (addr_match)
            w_state_nxt = rw ? RDATA : PTR;
        else if (stop_evt)
            w_state_nxt = IDLE;
        else if (w_load_ptr)
            w_state_nxt = WDATA;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ptr       <= 8'h00;
            r_tx        <= 8'h00;
            r_err       <= 1'b0;
            r_rw_regs   <= {RO_BASE{RW_RESET}};
            r_wr_strobe <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_wr_strobe <= '0;
            if (w_load_ptr) begin
                r_ptr <= rx;
                if ({1'b0, rx} >= NUM_REGS_W) r_err <= 1'b1;
            end else if (w_inc) begin
                r_ptr <= w_ptr_inc;
            end
            if (w_do_write) begin
                for (int i = 0; i < RO_BASE; i++) begin
                    if (r_ptr == 8'(i)) begin
                        r_rw_regs[i*8 +: 8] <= rx;
                        r_wr_strobe[i]      <= 1'b1;
                    end
                end
            end
            if (w_tx_upd) r_tx <= w_rd_byte;
        end
    end

    assign tx        = r_tx;
    assign rw_regs   = r_rw_regs;
    assign wr_strobe = r_wr_strobe;
    assign ptr       = r_ptr;
    assign err       = r_err;
    assign debug     = (r_state != IDLE);

endmodule
